// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared definitions for the intersection sequencer: timer count
//               width, phase encodings (3-bit binary), lamp encodings and a
//               helper that maps a phase to its {main, side} lamp pair.
// Revision    : 1.0  initial release
// ============================================================================
package traffic_pkg;

    localparam int COUNT_W = 2;
    localparam int STATE_W = 3;

    // Phase encodings; values 6 and 7 are illegal and force recovery.
    localparam logic [STATE_W-1:0] c_MAIN_GREEN  = 3'd0;
    localparam logic [STATE_W-1:0] c_MAIN_YELLOW = 3'd1;
    localparam logic [STATE_W-1:0] c_RED_TO_SIDE = 3'd2;
    localparam logic [STATE_W-1:0] c_SIDE_GREEN  = 3'd3;
    localparam logic [STATE_W-1:0] c_SIDE_YELLOW = 3'd4;
    localparam logic [STATE_W-1:0] c_RED_TO_MAIN = 3'd5;

    // Lamp encodings, {red, yellow, green}.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Returns {main_light, side_light} for a phase. Anything that is not a
    // green or yellow phase shows red on both streets, so an illegal code
    // can never light a green.
    function automatic logic [5:0] lamps_for(input logic [STATE_W-1:0] state);
        logic [5:0] lamps;
        case (state)
            c_MAIN_GREEN:  lamps = {LAMP_GRN, LAMP_RED};
            c_MAIN_YELLOW: lamps = {LAMP_YEL, LAMP_RED};
            c_SIDE_GREEN:  lamps = {LAMP_RED, LAMP_GRN};
            c_SIDE_YELLOW: lamps = {LAMP_RED, LAMP_YEL};
            default:       lamps = {LAMP_RED, LAMP_RED};
        endcase
        return lamps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/request_latch.sv
`default_nettype none
// ============================================================================
// Module      : request_latch
// Description : Sticky service-request flag. Set by a level input, cleared
//               by a one-cycle clear strobe; clear has priority over set.
// Ports       : clock    in  1  system clock, rising edge
//               reset_n  in  1  asynchronous active-low reset (flag -> 0)
//               i_set    in  1  request set
//               i_clear  in  1  request clear (wins over i_set)
//               o_req    out 1  registered request flag
// Revision    : 1.0  initial release
// ============================================================================
module request_latch (
    input  logic clock,
    input  logic reset_n,
    input  logic i_set,
    input  logic i_clear,
    output logic o_req
);

    logic r_req;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_req <= 1'b0;
        end else if (i_clear) begin
            r_req <= 1'b0;
        end else if (i_set) begin
            r_req <= 1'b1;
        end
    end

    assign o_req = r_req;

endmodule
`default_nettype wire

// File: rtl/traffic_light_controller.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_controller
// Description : Intersection sequencer. Walks the six-phase cycle
//               MAIN_GREEN -> MAIN_YELLOW -> RED_TO_SIDE -> SIDE_GREEN ->
//               SIDE_YELLOW -> RED_TO_MAIN, timing each phase from the
//               external phase timer's saturating count and restarting that
//               timer on every phase change.
// Ports       : clock          in   1  system clock, rising edge
//               sys_reset_n    in   1  asynchronous active-low reset
//               count          in   2  timer dwell count (saturates at 3)
//               side_sensor    in   1  side-street vehicle present
//               ped_button     in   1  pedestrian request  (PED_WALK_EN only)
//               ped_walk       out  1  walk lamp           (PED_WALK_EN only)
//               timer_restart  out  1  registered timer restart strobe
//               main_light     out  3  {red,yellow,green} one-hot
//               side_light     out  3  {red,yellow,green} one-hot
// Macro       : PED_WALK_EN  adds the pedestrian request/walk feature
// Revision    : 1.0  initial release
// ============================================================================
module traffic_light_controller
    import traffic_pkg::*;
#(
    parameter logic [COUNT_W-1:0] MAIN_GREEN_MIN = 2'd3,
    parameter logic [COUNT_W-1:0] SIDE_GREEN_T   = 2'd2,
    parameter logic [COUNT_W-1:0] YELLOW_T       = 2'd1,
    parameter logic [COUNT_W-1:0] ALL_RED_T      = 2'd0
) (
    input  logic               clock,
    input  logic               sys_reset_n,
    input  logic [COUNT_W-1:0] count,
    input  logic               side_sensor,
`ifdef PED_WALK_EN
    input  logic               ped_button,
    output logic               ped_walk,
`endif
    output logic               timer_restart,
    output logic [2:0]         main_light,
    output logic [2:0]         side_light
);

    logic [STATE_W-1:0] r_state;
    logic               r_timer_restart;
    logic [2:0]         r_main_light;
    logic [2:0]         r_side_light;

    logic [STATE_W-1:0] w_next_state;
    logic [COUNT_W-1:0] w_threshold;
    logic               w_expired;
    logic               w_phase_change;
    logic               w_enter_side;
    logic               w_set_allowed;
    logic               w_side_req;
    logic               w_service_req;

    // Dwell threshold of the current phase.
    always_comb begin
        w_threshold = ALL_RED_T;
        case (r_state)
            c_MAIN_GREEN:  w_threshold = MAIN_GREEN_MIN;
            c_MAIN_YELLOW: w_threshold = YELLOW_T;
            c_SIDE_GREEN:  w_threshold = SIDE_GREEN_T;
            c_SIDE_YELLOW: w_threshold = YELLOW_T;
            default:       w_threshold = ALL_RED_T;
        endcase
    end

    // While the restart strobe is high the timer has not yet been cleared,
    // so the count still belongs to the previous phase and must be ignored.
    assign w_expired = !r_timer_restart && (count >= w_threshold);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_MAIN_GREEN:  if (w_expired && w_service_req) w_next_state = c_MAIN_YELLOW;
            c_MAIN_YELLOW: if (w_expired) w_next_state = c_RED_TO_SIDE;
            c_RED_TO_SIDE: if (w_expired) w_next_state = c_SIDE_GREEN;
            c_SIDE_GREEN:  if (w_expired) w_next_state = c_SIDE_YELLOW;
            c_SIDE_YELLOW: if (w_expired) w_next_state = c_RED_TO_MAIN;
            c_RED_TO_MAIN: if (w_expired) w_next_state = c_MAIN_GREEN;
            default:       w_next_state = c_RED_TO_MAIN;
        endcase
    end

    // An illegal code always differs from RED_TO_MAIN, so recovery also
    // raises the restart strobe through this compare.
    assign w_phase_change = (w_next_state != r_state);
    assign w_enter_side   = (r_state != c_SIDE_GREEN) && (w_next_state == c_SIDE_GREEN);
    assign w_set_allowed  = (r_state != c_SIDE_GREEN);

    request_latch u_side_req (
        .clock   (clock),
        .reset_n (sys_reset_n),
        .i_set   (side_sensor && w_set_allowed),
        .i_clear (w_enter_side),
        .o_req   (w_side_req)
    );

`ifdef PED_WALK_EN
    logic w_ped_req;
    logic r_ped_walk;

    request_latch u_ped_req (
        .clock   (clock),
        .reset_n (sys_reset_n),
        .i_set   (ped_button && w_set_allowed),
        .i_clear (w_enter_side),
        .o_req   (w_ped_req)
    );

    assign w_service_req = w_side_req || w_ped_req;

    // Walk is decided once, at SIDE_GREEN entry, from the request as it
    // stood before the entry clear, and held for the whole green.
    always_ff @(posedge clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_ped_walk <= 1'b0;
        end else if (w_enter_side) begin
            r_ped_walk <= w_ped_req;
        end else if (w_next_state != c_SIDE_GREEN) begin
            r_ped_walk <= 1'b0;
        end
    end

    assign ped_walk = r_ped_walk;
`else
    assign w_service_req = w_side_req;
`endif

    // State and lamps update on the same edge; lamps come from the next
    // state so they never lag the phase.
    always_ff @(posedge clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_state         <= c_MAIN_GREEN;
            r_timer_restart <= 1'b1;
            r_main_light    <= LAMP_GRN;
            r_side_light    <= LAMP_RED;
        end else begin
            r_state                       <= w_next_state;
            r_timer_restart               <= w_phase_change;
            {r_main_light, r_side_light}  <= lamps_for(w_next_state);
        end
    end

    assign timer_restart = r_timer_restart;
    assign main_light    = r_main_light;
    assign side_light    = r_side_light;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_traffic_light_controller
// Description : Self-checking bench for traffic_light_controller. Provides
//               the phase timer the controller closes its loop through and
//               a phase/elapsed-cycle reference model of the intersection.
// Macro       : PED_WALK_EN  enables the pedestrian scenario
// Revision    : 1.0  initial release
// ============================================================================
module tb_traffic_light_controller;

    logic       clock = 1'b0;
    logic       sys_reset_n;
    logic [1:0] count = 2'd0;
    logic       side_sensor;
    logic       timer_restart;
    logic [2:0] main_light;
    logic [2:0] side_light;
`ifdef PED_WALK_EN
    logic       ped_button;
    logic       ped_walk;
`endif

    always #5 clock = ~clock;

    traffic_light_controller dut (
        .clock         (clock),
        .sys_reset_n   (sys_reset_n),
        .count         (count),
        .side_sensor   (side_sensor),
`ifdef PED_WALK_EN
        .ped_button    (ped_button),
        .ped_walk      (ped_walk),
`endif
        .timer_restart (timer_restart),
        .main_light    (main_light),
        .side_light    (side_light)
    );

    // Phase timer: synchronous restart, +1 per cycle, saturating at 3.
    always @(posedge clock) begin
        if (timer_restart)      count <= 2'd0;
        else if (count != 2'd3) count <= count + 2'd1;
    end

    // ---------------- reference model ----------------
    // Phase index 0..5 in cycle order; m_k = cycles spent in the phase so
    // far (0 = the restart cycle). A phase with threshold T may exit at the
    // end of any cycle with m_k >= T+1, giving a minimum dwell of T+2.
    int         t_tab [6]    = '{3, 1, 0, 2, 1, 0};
    logic [2:0] main_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] side_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    int m_phase, m_k, m_changes;
    bit m_req, m_ped, m_walk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic model_reset();
        m_phase = 0; m_k = 0; m_req = 0; m_ped = 0; m_walk = 0;
    endtask

    task automatic model_edge(input bit sensor, input bit ped);
        bit leave;
        int nxt;
        leave = (m_k >= t_tab[m_phase] + 1) && (m_phase != 0 || m_req || m_ped);
        if (m_phase != 3) begin
            m_req = m_req | sensor;
            m_ped = m_ped | ped;
        end
        if (leave) begin
            nxt = (m_phase + 1) % 6;
            if (nxt == 3) begin
                m_walk = m_ped;
                m_req  = 0;
                m_ped  = 0;
            end
            if (m_phase == 3) m_walk = 0;
            m_phase = nxt;
            m_k     = 0;
            m_changes++;
        end else if (m_k < 1000) begin
            m_k++;
        end
    endtask

    // One clock cycle: drive inputs after a falling edge, advance DUT and
    // model on the rising edge, return at the next falling edge for checks.
    task automatic cycle(input bit sensor, input bit ped);
        side_sensor = sensor;
`ifdef PED_WALK_EN
        ped_button  = ped;
`endif
        @(posedge clock);
        model_edge(sensor, ped);
        @(negedge clock);
        cyc++;
    endtask

    task automatic apply_reset(input int n);
        sys_reset_n = 1'b0;
        side_sensor = 1'b0;
`ifdef PED_WALK_EN
        ped_button  = 1'b0;
`endif
        repeat (n) @(negedge clock);
        sys_reset_n = 1'b1;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        sys_reset_n = 1'b0;
        side_sensor = 1'b0;
`ifdef PED_WALK_EN
        ped_button  = 1'b0;
`endif
        repeat (3) @(negedge clock);
        n_checks++;
        if ({timer_restart, main_light, side_light} !== {1'b1, 3'b001, 3'b100})
            $display("FAIL reset_held: got rst=%b main=%b side=%b want rst=1 main=001 side=100",
                     timer_restart, main_light, side_light);
        else n_pass++;
        sys_reset_n = 1'b1;
        model_reset();
        n_checks++;
        if (timer_restart !== 1'b1)
            $display("FAIL reset_release_restart: got %b want 1", timer_restart);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0);
            n_checks++;
            if ({timer_restart, main_light, side_light} !== {1'b0, 3'b001, 3'b100})
                $display("FAIL idle_main_green cyc %0d: got rst=%b main=%b side=%b want rst=0 main=001 side=100",
                         i, timer_restart, main_light, side_light);
            else n_pass++;
        end
    endtask

    task automatic test_single_pulse();
        int last, dwells[$];
        int exp_d [5] = '{3, 2, 4, 3, 2};
        last = -1;
        apply_reset(2);
        for (int i = 0; i < 40; i++) begin
            cycle(i == 10, 1'b0);
            n_checks++;
            if ({main_light, side_light, timer_restart} !== {main_tab[m_phase], side_tab[m_phase], (m_k == 0)})
                $display("FAIL pulse_seq cyc %0d: got main=%b side=%b rst=%b want main=%b side=%b rst=%b",
                         i, main_light, side_light, timer_restart, main_tab[m_phase], side_tab[m_phase], (m_k == 0));
            else n_pass++;
            if (timer_restart) begin
                if (last >= 0) dwells.push_back(i - last);
                last = i;
            end
        end
        n_checks++;
        if (dwells.size() != 5)
            $display("FAIL pulse_phase_count: got %0d dwell intervals want 5", dwells.size());
        else begin
            n_pass++;
            for (int j = 0; j < 5; j++) begin
                n_checks++;
                if (dwells[j] != exp_d[j])
                    $display("FAIL pulse_dwell[%0d]: got %0d want %0d", j, dwells[j], exp_d[j]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_continuous();
        int dut_rst;
        bit s;
        dut_rst = 0;
        apply_reset(2);
        m_changes = 0;
        for (int i = 0; i < 260; i++) begin
            s = (i < 60) ? 1'b1 : ($urandom_range(0, 3) == 0);
            cycle(s, 1'b0);
            if (timer_restart === 1'b1) dut_rst++;
            n_checks++;
            if (main_light[0] === 1'b1 && side_light[0] === 1'b1)
                $display("FAIL both_green cyc %0d: got main=%b side=%b want at most one green",
                         i, main_light, side_light);
            else n_pass++;
            n_checks++;
            if ({main_light, side_light, timer_restart} !== {main_tab[m_phase], side_tab[m_phase], (m_k == 0)})
                $display("FAIL cycling cyc %0d: got main=%b side=%b rst=%b want main=%b side=%b rst=%b",
                         i, main_light, side_light, timer_restart, main_tab[m_phase], side_tab[m_phase], (m_k == 0));
            else n_pass++;
        end
        n_checks++;
        if (dut_rst != m_changes)
            $display("FAIL restart_per_phase: got %0d restart pulses want %0d", dut_rst, m_changes);
        else n_pass++;
    endtask

    task automatic test_yellow_retained();
        bit pulsed, in_mg, measured;
        int start, dwell;
        pulsed = 0; in_mg = 0; measured = 0; start = 0; dwell = 0;
        apply_reset(2);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 60; i++) begin
            if (!pulsed && m_phase == 4) begin
                pulsed = 1;
                cycle(1'b1, 1'b0);
            end else begin
                cycle(1'b0, 1'b0);
            end
            n_checks++;
            if ({main_light, side_light, timer_restart} !== {main_tab[m_phase], side_tab[m_phase], (m_k == 0)})
                $display("FAIL yellow_seq cyc %0d: got main=%b side=%b rst=%b want main=%b side=%b rst=%b",
                         i, main_light, side_light, timer_restart, main_tab[m_phase], side_tab[m_phase], (m_k == 0));
            else n_pass++;
            if (pulsed && !measured && timer_restart === 1'b1) begin
                if (in_mg) begin
                    dwell = i - start;
                    measured = 1;
                end else if (main_light === 3'b001) begin
                    in_mg = 1;
                    start = i;
                end
            end
        end
        n_checks++;
        if (!measured || dwell != 5)
            $display("FAIL retained_main_dwell: got %0d (measured=%0d) want 5", dwell, measured);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        bit found;
        found = 0;
        apply_reset(2);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, 1'b0);
            if (m_phase == 3 && m_k == 1) found = 1;
        end
        n_checks++;
        if (!found || side_light !== 3'b001)
            $display("FAIL reach_side_green: got side=%b found=%0d want side=001", side_light, found);
        else n_pass++;
        #2 sys_reset_n = 1'b0;
        #1;
        n_checks++;
        if ({timer_restart, main_light, side_light} !== {1'b1, 3'b001, 3'b100})
            $display("FAIL async_reset_sg: got rst=%b main=%b side=%b want rst=1 main=001 side=100",
                     timer_restart, main_light, side_light);
        else n_pass++;
        apply_reset(2);
        // Leave a request pending in MAIN_GREEN, then reset before it is served.
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        #2 sys_reset_n = 1'b0;
        #1;
        n_checks++;
        if ({timer_restart, main_light, side_light} !== {1'b1, 3'b001, 3'b100})
            $display("FAIL async_reset_mg: got rst=%b main=%b side=%b want rst=1 main=001 side=100",
                     timer_restart, main_light, side_light);
        else n_pass++;
        apply_reset(2);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0);
            n_checks++;
            if ({main_light, side_light} !== 6'b001_100)
                $display("FAIL req_dropped cyc %0d: got main=%b side=%b want main=001 side=100",
                         i, main_light, side_light);
            else n_pass++;
        end
    endtask

`ifdef PED_WALK_EN
    task automatic test_ped_walk();
        int walk_cycles;
        walk_cycles = 0;
        apply_reset(2);
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, i == 3);
            if (ped_walk === 1'b1) walk_cycles++;
            n_checks++;
            if ({main_light, side_light, ped_walk} !== {main_tab[m_phase], side_tab[m_phase], m_walk})
                $display("FAIL ped_seq cyc %0d: got main=%b side=%b walk=%b want main=%b side=%b walk=%b",
                         i, main_light, side_light, ped_walk, main_tab[m_phase], side_tab[m_phase], m_walk);
            else n_pass++;
        end
        n_checks++;
        if (walk_cycles != 4)
            $display("FAIL ped_walk_len: got %0d cycles want 4", walk_cycles);
        else n_pass++;
    endtask
`endif

    initial begin
        m_changes = 0;
        model_reset();
        test_reset();
        test_single_pulse();
        test_continuous();
        test_yellow_retained();
        test_async_reset();
`ifdef PED_WALK_EN
        test_ped_walk();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
